// File: rtl/pcc_pkg.sv
// pcc_pkg: shared types and sizing helpers for the streaming popcount comparator.
//
// Contents:
//   pcc_state_t - controller state (IDLE, ACCUM, DONE)
//   pcc_beats() - number of accumulate cycles: ceil(max(npos,nneg)/chunk)
//   pcc_dw()    - signed accumulator width: clog2(npos+nneg+1)+2
//
// Optional feature macro used by the files that import this package:
//   PCC_DIFF_OUT_EN - adds the registered signed difference output 'diff'.
package pcc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } pcc_state_t;

    function automatic int pcc_beats(input int npos, input int nneg, input int chunk);
        int widest;
        widest = (npos > nneg) ? npos : nneg;
        return (widest + chunk - 1) / chunk;
    endfunction

    // Two guard bits above the magnitude range leave room for the sign and
    // for any BIAS that fits the stated range.
    function automatic int pcc_dw(input int npos, input int nneg);
        return $clog2(npos + nneg + 1) + 2;
    endfunction

endpackage : pcc_pkg

// File: rtl/pcc_stream_if.sv
// pcc_stream_if: valid/ready bundle between a vote-bit producer/result
// consumer (master) and the pcc_stream comparator (slave).
//
// Signals:
//   in_valid / in_ready   - input transaction handshake
//   pos [N_POS]           - positive vote bits
//   neg [N_NEG]           - negative vote bits
//   out_valid / out_ready - result handshake
//   outval                - 1 when popcount(pos)-popcount(neg)+BIAS >= 0
//   diff [DW]             - signed difference (only with PCC_DIFF_OUT_EN)
interface pcc_stream_if #(
    parameter int N_POS = 6,
    parameter int N_NEG = 9
);
`ifdef PCC_DIFF_OUT_EN
    localparam int DW = pcc_pkg::pcc_dw(N_POS, N_NEG);
`endif

    logic             in_valid;
    logic             in_ready;
    logic [N_POS-1:0] pos;
    logic [N_NEG-1:0] neg;
    logic             out_valid;
    logic             out_ready;
    logic             outval;
`ifdef PCC_DIFF_OUT_EN
    logic [DW-1:0]    diff;
`endif

    modport master (
        output in_valid, pos, neg, out_ready,
        input  in_ready, out_valid, outval
`ifdef PCC_DIFF_OUT_EN
        , input diff
`endif
    );

    modport slave (
        input  in_valid, pos, neg, out_ready,
        output in_ready, out_valid, outval
`ifdef PCC_DIFF_OUT_EN
        , output diff
`endif
    );

endinterface : pcc_stream_if

// File: rtl/pcc_chunk_popcount.sv
// pcc_chunk_popcount: combinational population count of one CHUNK-bit slice.
//
// Ports:
//   bits  [CHUNK]           - slice to count
//   count [clog2(CHUNK+1)]  - number of set bits in 'bits'
module pcc_chunk_popcount #(
    parameter int CHUNK = 4,
    localparam int CW = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] bits,
    output logic [CW-1:0]    count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule : pcc_chunk_popcount

// File: rtl/pcc_stream.sv
// pcc_stream: multi-cycle popcount comparator.
//
// Captures one positive and one negative vote vector per transaction, counts
// CHUNK bits of each per cycle into a signed accumulator preloaded with BIAS,
// and presents outval = (popcount(pos) - popcount(neg) + BIAS >= 0) until the
// consumer takes it. No transactions overlap: in_ready is only high in IDLE.
//
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset (synchronous release expected)
//   bus   - pcc_stream_if.slave: in_valid/in_ready/pos/neg,
//           out_valid/out_ready/outval, and diff when PCC_DIFF_OUT_EN is set
//
// Optional feature macro: PCC_DIFF_OUT_EN - drives bus.diff with the final
// signed difference, registered, held between results, reset to 0.
module pcc_stream
    import pcc_pkg::*;
#(
    parameter int N_POS = 6,
    parameter int N_NEG = 9,
    parameter int CHUNK = 4,
    parameter int BIAS  = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    pcc_stream_if.slave  bus
);

    localparam int BEATS = pcc_beats(N_POS, N_NEG, CHUNK);
    localparam int DW    = pcc_dw(N_POS, N_NEG);
    localparam int PADW  = BEATS * CHUNK;
    localparam int CW    = $clog2(CHUNK + 1);
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [KW-1:0] LAST_BEAT = KW'(BEATS - 1);
    localparam logic [DW-1:0] BIAS_DW   = DW'(BIAS);

    pcc_state_t state_reg;
    pcc_state_t state_next;

    logic [PADW-1:0]  pos_ext;
    logic [PADW-1:0]  neg_ext;
    logic [PADW-1:0]  pos_reg;
    logic [PADW-1:0]  neg_reg;
    logic [KW-1:0]    beat_reg;
    logic [DW-1:0]    acc_reg;
    logic [DW-1:0]    acc_next;

    logic [CHUNK-1:0] pos_chunk [BEATS];
    logic [CHUNK-1:0] neg_chunk [BEATS];
    logic [CHUNK-1:0] pos_sel;
    logic [CHUNK-1:0] neg_sel;
    logic [CW-1:0]    pos_cnt;
    logic [CW-1:0]    neg_cnt;

    logic             accept;
    logic             last_beat;

    // ------------------------------------------------------------------
    // Zero-extend the inputs to a whole number of chunks so the padding
    // bits above N_POS/N_NEG contribute nothing to the counts.
    // ------------------------------------------------------------------
    always_comb begin
        pos_ext = '0;
        neg_ext = '0;
        pos_ext[N_POS-1:0] = bus.pos;
        neg_ext[N_NEG-1:0] = bus.neg;
    end

    // Slice the captured vectors into chunks; the beat counter picks one.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_chunk
            assign pos_chunk[gi] = pos_reg[gi*CHUNK +: CHUNK];
            assign neg_chunk[gi] = neg_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign pos_sel = pos_chunk[beat_reg];
    assign neg_sel = neg_chunk[beat_reg];

    pcc_chunk_popcount #(.CHUNK(CHUNK)) u_pos_count (
        .bits  (pos_sel),
        .count (pos_cnt)
    );

    pcc_chunk_popcount #(.CHUNK(CHUNK)) u_neg_count (
        .bits  (neg_sel),
        .count (neg_cnt)
    );

    assign accept    = (state_reg == IDLE) && bus.in_valid;
    assign last_beat = (beat_reg == LAST_BEAT);

    // Counts are unsigned and narrower than DW, so the casts zero-extend;
    // the sum wraps in two's complement, which DW keeps from overflowing.
    assign acc_next = acc_reg + DW'(pos_cnt) - DW'(neg_cnt);

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.outval    = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.outval    = ~acc_reg[DW-1];
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: capture registers, beat counter, accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_reg  <= '0;
            neg_reg  <= '0;
            beat_reg <= '0;
            acc_reg  <= '0;
        end else if (accept) begin
            pos_reg  <= pos_ext;
            neg_reg  <= neg_ext;
            beat_reg <= '0;
            acc_reg  <= BIAS_DW;
        end else if (state_reg == ACCUM) begin
            acc_reg  <= acc_next;
            beat_reg <= last_beat ? '0 : beat_reg + KW'(1);
        end
    end

`ifdef PCC_DIFF_OUT_EN
    logic [DW-1:0] diff_reg;

    // Loaded with the same value the accumulator takes on entering DONE,
    // so it matches the accumulator throughout DONE and holds afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_reg <= '0;
        end else if ((state_reg == ACCUM) && last_beat) begin
            diff_reg <= acc_next;
        end
    end

    assign bus.diff = diff_reg;
`endif

endmodule : pcc_stream

// File: tb/tb_pcc_stream.sv
// tb_pcc_stream: self-checking bench for pcc_stream.
// Two instances: defaults (6/9/4/0) and a wide one (16/16/5/-1).
// Expected results come from popcount arithmetic on the applied vectors.
module tb_pcc_stream;
    import pcc_pkg::*;

    localparam int A_NPOS = 6,  A_NNEG = 9,  A_CHUNK = 4, A_BIAS = 0;
    localparam int B_NPOS = 16, B_NNEG = 16, B_CHUNK = 5, B_BIAS = -1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pcc_stream_if #(.N_POS(A_NPOS), .N_NEG(A_NNEG)) bus_a ();
    pcc_stream_if #(.N_POS(B_NPOS), .N_NEG(B_NNEG)) bus_b ();

    pcc_stream #(.N_POS(A_NPOS), .N_NEG(A_NNEG), .CHUNK(A_CHUNK), .BIAS(A_BIAS)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    pcc_stream #(.N_POS(B_NPOS), .N_NEG(B_NNEG), .CHUNK(B_CHUNK), .BIAS(B_BIAS)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: plain popcount arithmetic on the masked vectors.
    function automatic int ref_diff(input int w, input logic [15:0] p, input logic [15:0] n);
        if (w == 0) return $countones(p[A_NPOS-1:0]) - $countones(n[A_NNEG-1:0]) + A_BIAS;
        return $countones(p[B_NPOS-1:0]) - $countones(n[B_NNEG-1:0]) + B_BIAS;
    endfunction

    // Edges from the accept edge (inclusive) to the edge raising out_valid.
    function automatic int ref_lat(input int w);
        int np, nn, ch, widest;
        np = (w == 0) ? A_NPOS : B_NPOS;
        nn = (w == 0) ? A_NNEG : B_NNEG;
        ch = (w == 0) ? A_CHUNK : B_CHUNK;
        widest = (np > nn) ? np : nn;
        return (widest + ch - 1) / ch + 1;
    endfunction

    task automatic drive(input int w, input logic v, input logic [15:0] p,
                         input logic [15:0] n, input logic ordy);
        if (w == 0) begin
            bus_a.in_valid  = v;
            bus_a.pos       = p[A_NPOS-1:0];
            bus_a.neg       = n[A_NNEG-1:0];
            bus_a.out_ready = ordy;
        end else begin
            bus_b.in_valid  = v;
            bus_b.pos       = p;
            bus_b.neg       = n;
            bus_b.out_ready = ordy;
        end
    endtask

    task automatic sample(input int w, output logic ir, output logic ov,
                          output logic o, output logic signed [31:0] d);
        d = 0;
        if (w == 0) begin
            ir = bus_a.in_ready; ov = bus_a.out_valid; o = bus_a.outval;
`ifdef PCC_DIFF_OUT_EN
            d = $signed(bus_a.diff);
`endif
        end else begin
            ir = bus_b.in_ready; ov = bus_b.out_valid; o = bus_b.outval;
`ifdef PCC_DIFF_OUT_EN
            d = $signed(bus_b.diff);
`endif
        end
    endtask

    // One full transaction: accept, wait for result, hold it 'hold' cycles
    // with in_valid toggling, then release it.
    task automatic txn(input int w, input logic [15:0] p, input logic [15:0] n,
                       input int hold, input string tag);
        logic ir, ov, o, o_first;
        logic signed [31:0] d, d_first;
        int exp_d, cnt;
        exp_d = ref_diff(w, p, n);
        sample(w, ir, ov, o, d);
        check({tag, ".in_ready_idle"}, ir, 1);
        drive(w, 1'b1, p, n, 1'b0);
        @(posedge clk); #1;
        drive(w, 1'b0, 16'($urandom), 16'($urandom), 1'b0);
        cnt = 1;
        sample(w, ir, ov, o, d);
        check({tag, ".in_ready_busy"}, ir, 0);
        while (!ov && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
            sample(w, ir, ov, o, d);
        end
        check({tag, ".latency"}, cnt, ref_lat(w));
        check({tag, ".outval"}, o, (exp_d >= 0) ? 1 : 0);
`ifdef PCC_DIFF_OUT_EN
        check({tag, ".diff"}, d, exp_d);
`endif
        o_first = o;
        d_first = d;
        for (int i = 0; i < hold; i++) begin
            drive(w, logic'(i % 2 == 0), 16'($urandom), 16'($urandom), 1'b0);
            @(posedge clk); #1;
            sample(w, ir, ov, o, d);
            check({tag, ".hold_valid"}, ov, 1);
            check({tag, ".hold_ready"}, ir, 0);
            check({tag, ".hold_outval"}, o, o_first);
            check({tag, ".hold_diff"}, d, d_first);
        end
        drive(w, 1'b0, 16'h0, 16'h0, 1'b1);
        @(posedge clk); #1;
        sample(w, ir, ov, o, d);
        check({tag, ".release_valid"}, ov, 0);
        check({tag, ".release_ready"}, ir, 1);
        drive(w, 1'b0, 16'h0, 16'h0, 1'b0);
        $display("txn %s dut=%0d pos=%h neg=%h exp_diff=%0d outval=%0b lat=%0d",
                 tag, w, p, n, exp_d, o_first, cnt);
    endtask

    initial begin
        logic ir, ov, o;
        logic signed [31:0] d;
        int seen;

        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sample(0, ir, ov, o, d);
        check("reset.in_ready", ir, 1);
        check("reset.out_valid", ov, 0);
        check("reset.outval", o, 0);
`ifdef PCC_DIFF_OUT_EN
        check("reset.diff", d, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases on the default instance.
        txn(0, 16'h003F, 16'h0000, 0, "all_pos");
        txn(0, 16'h0000, 16'h01FF, 0, "all_neg");
        txn(0, 16'h0007, 16'h0103, 0, "tie");
        txn(0, 16'h0001, 16'h0100, 5, "stall");

        // Reset during the second accumulate beat drops the transaction.
        drive(0, 1'b1, 16'h003F, 16'h0000, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        sample(0, ir, ov, o, d);
        check("midreset.out_valid", ov, 0);
        check("midreset.in_ready", ir, 1);
`ifdef PCC_DIFF_OUT_EN
        check("midreset.diff", d, 0);
`endif
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            sample(0, ir, ov, o, d);
            if (ov) seen++;
        end
        check("midreset.no_result", seen, 0);
        $display("txn midreset dut=0 dropped, results seen=%0d", seen);
        txn(0, 16'h0015, 16'h0003, 0, "after_reset");

        // Wide instance: BIAS=-1, CHUNK=5, four beats.
        txn(1, 16'h00FF, 16'h00FF, 0, "bias_neg");
        txn(1, 16'h01FF, 16'h00FF, 0, "bias_tie");
        txn(1, 16'hFFFF, 16'hFFFF, 1, "wide_full");

        // Randomized traffic on both instances.
        for (int i = 0; i < 15; i++) begin
            txn(0, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), "rand_a");
        end
        for (int i = 0; i < 10; i++) begin
            txn(1, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), "rand_b");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pcc_stream
